// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and types for the register-file write arbiter.
// Define RF_WR_RR_EN to switch arbitration from fixed-priority-A to round-robin.
package rf_write_arbiter_pkg;

   localparam int DATA_W     = 32;
   localparam int ADDR_W     = 4;
   localparam int NUM_REGS   = 15;
   localparam int STARVE_MAX = 4;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_sel_e;

   typedef struct packed {
      logic [ADDR_W-1:0] dest;
      logic [DATA_W-1:0] data;
   } wr_req_t;

endpackage

// File: rtl/rf_write_arbiter_grant.sv
// Combinational ready/grant logic with its arbitration state.
// Default: fixed priority to A with a starvation override; RF_WR_RR_EN selects round-robin.
module rf_wr_grant
   import rf_write_arbiter_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic a_valid,
   input  logic b_valid,
   output logic a_ready,
   output logic b_ready
);

`ifdef RF_WR_RR_EN
   req_sel_e prio_q, prio_d;

   always_comb begin
      b_ready = !rst && b_valid && (!a_valid || prio_q == REQ_B);
      a_ready = !rst && a_valid && !b_ready;
      prio_d  = prio_q;
      // Hand priority to whichever side did not just win.
      if (a_ready) begin
         prio_d = REQ_B;
      end else if (b_ready) begin
         prio_d = REQ_A;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prio_q <= REQ_A;
      end else begin
         prio_q <= prio_d;
      end
   end
`else
   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

   always_comb begin
      b_ready      = !rst && b_valid && (!a_valid || starve_cnt_q == CNT_W'(STARVE_MAX));
      a_ready      = !rst && a_valid && !b_ready;
      starve_cnt_d = starve_cnt_q;
      if (!b_valid || b_ready) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q != CNT_W'(STARVE_MAX)) begin
         starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end
`endif

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates two writeback sources onto the single register-file write port.
// Arbitration mode is chosen in rf_wr_grant via the RF_WR_RR_EN macro.
module rf_write_arbiter
   import rf_write_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              a_valid,
   input  logic [ADDR_W-1:0] a_dest,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [ADDR_W-1:0] b_dest,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   output logic              rf_reg_write,
   output logic [ADDR_W-1:0] rf_reg_dest,
   output logic [DATA_W-1:0] rf_data,
   output logic [NUM_REGS-1:0] pending_mask,
   output logic              illegal_dest
);

   logic              xfer;
   logic              legal;
   wr_req_t           req;
   logic              wr_valid_q, wr_valid_d;
   logic              illegal_q, illegal_d;
   logic [ADDR_W-1:0] dest_q, dest_d;
   logic [DATA_W-1:0] data_q, data_d;

   rf_wr_grant u_grant (
      .clk     (clk),
      .rst     (rst),
      .a_valid (a_valid),
      .b_valid (b_valid),
      .a_ready (a_ready),
      .b_ready (b_ready)
   );

   // Illegal destinations are consumed but never reach the port; dest/data keep the last legal write.
   always_comb begin
      xfer       = (a_valid && a_ready) || (b_valid && b_ready);
      req        = (b_valid && b_ready) ? '{dest: b_dest, data: b_data}
                                        : '{dest: a_dest, data: a_data};
      legal      = {1'b0, req.dest} < (ADDR_W + 1)'(NUM_REGS);
      wr_valid_d = xfer && legal;
      illegal_d  = xfer && !legal;
      dest_d     = dest_q;
      data_d     = data_q;
      if (wr_valid_d) begin
         dest_d = req.dest;
         data_d = req.data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_valid_q <= 1'b0;
         illegal_q  <= 1'b0;
         dest_q     <= '0;
         data_q     <= '0;
      end else begin
         wr_valid_q <= wr_valid_d;
         illegal_q  <= illegal_d;
         dest_q     <= dest_d;
         data_q     <= data_d;
      end
   end

   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         pending_mask[i] = wr_valid_q && (dest_q == ADDR_W'(i));
      end
   end

   assign rf_reg_write = wr_valid_q;
   assign rf_reg_dest  = dest_q;
   assign rf_data      = data_q;
   assign illegal_dest = illegal_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Table-driven bench for rf_write_arbiter; expected arbitration rows follow RF_WR_RR_EN.
module tb_rf_write_arbiter;
   import rf_write_arbiter_pkg::*;

   typedef struct {
      logic              rst;
      logic              a_valid;
      logic [ADDR_W-1:0] a_dest;
      logic [DATA_W-1:0] a_data;
      logic              b_valid;
      logic [ADDR_W-1:0] b_dest;
      logic [DATA_W-1:0] b_data;
      logic              exp_a_ready;
      logic              exp_b_ready;
      logic              exp_wr;
      logic [ADDR_W-1:0] exp_dest;
      logic [DATA_W-1:0] exp_data;
      logic [NUM_REGS-1:0] exp_mask;
      logic              exp_illegal;
   } vec_t;

   localparam int NUM_VEC = 19;

   logic              clk = 1'b0;
   logic              rst;
   logic              a_valid, b_valid;
   logic [ADDR_W-1:0] a_dest, b_dest;
   logic [DATA_W-1:0] a_data, b_data;
   logic              a_ready, b_ready;
   logic              rf_reg_write;
   logic [ADDR_W-1:0] rf_reg_dest;
   logic [DATA_W-1:0] rf_data;
   logic [NUM_REGS-1:0] pending_mask;
   logic              illegal_dest;

   logic [DATA_W-1:0] regfile [NUM_REGS];
   vec_t              vecs [NUM_VEC];
   int                checks = 0;
   int                errors = 0;

   always #5 clk = ~clk;

   rf_write_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .a_valid      (a_valid),
      .a_dest       (a_dest),
      .a_data       (a_data),
      .a_ready      (a_ready),
      .b_valid      (b_valid),
      .b_dest       (b_dest),
      .b_data       (b_data),
      .b_ready      (b_ready),
      .rf_reg_write (rf_reg_write),
      .rf_reg_dest  (rf_reg_dest),
      .rf_data      (rf_data),
      .pending_mask (pending_mask),
      .illegal_dest (illegal_dest)
   );

   // Register-file model: commits on the negedge after the write is presented.
   always @(negedge clk) begin
      if (rf_reg_write && rf_reg_dest < ADDR_W'(NUM_REGS)) begin
         regfile[rf_reg_dest] <= rf_data;
      end
   end

   function automatic vec_t mk(input logic r, input logic av, input logic [3:0] ad,
                               input logic [31:0] adat, input logic bv, input logic [3:0] bd,
                               input logic [31:0] bdat, input logic ar, input logic br,
                               input logic wr, input logic [3:0] ed, input logic [31:0] edat,
                               input logic [14:0] em, input logic ei);
      vec_t v;
      v.rst = r; v.a_valid = av; v.a_dest = ad; v.a_data = adat;
      v.b_valid = bv; v.b_dest = bd; v.b_data = bdat;
      v.exp_a_ready = ar; v.exp_b_ready = br; v.exp_wr = wr;
      v.exp_dest = ed; v.exp_data = edat; v.exp_mask = em; v.exp_illegal = ei;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp_v);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      rst     = v.rst;
      a_valid = v.a_valid;
      a_dest  = v.a_dest;
      a_data  = v.a_data;
      b_valid = v.b_valid;
      b_dest  = v.b_dest;
      b_data  = v.b_data;
   endtask

   task automatic checkOutput(input int idx, input vec_t v);
      check($sformatf("v%0d rf_reg_write", idx), 64'(rf_reg_write), 64'(v.exp_wr));
      check($sformatf("v%0d rf_reg_dest", idx), 64'(rf_reg_dest), 64'(v.exp_dest));
      check($sformatf("v%0d rf_data", idx), 64'(rf_data), 64'(v.exp_data));
      check($sformatf("v%0d pending_mask", idx), 64'(pending_mask), 64'(v.exp_mask));
      check($sformatf("v%0d illegal_dest", idx), 64'(illegal_dest), 64'(v.exp_illegal));
   endtask

   initial begin
      for (int i = 0; i < NUM_REGS; i++) regfile[i] = '0;

      // Reset held two cycles with both requesters valid.
      vecs[0]  = mk(1, 1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2, 0, 0, 0, 4'd0, 32'h0, 15'h0, 0);
      vecs[1]  = mk(1, 1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2, 0, 0, 0, 4'd0, 32'h0, 15'h0, 0);
      vecs[2]  = mk(0, 1, 4'd3, 32'hDEAD_BEEF, 0, 4'd0, 32'h0, 1, 0, 1, 4'd3, 32'hDEAD_BEEF, 15'h0008, 0);
      vecs[3]  = mk(0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 0, 0, 4'd3, 32'hDEAD_BEEF, 15'h0, 0);
`ifdef RF_WR_RR_EN
      // A won last, so contention starts with B and alternates.
      vecs[4]  = mk(0, 1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2, 0, 1, 1, 4'd2, 32'hB2, 15'h0004, 0);
      vecs[5]  = mk(0, 1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2, 1, 0, 1, 4'd1, 32'hA1, 15'h0002, 0);
      vecs[6]  = mk(0, 1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2, 0, 1, 1, 4'd2, 32'hB2, 15'h0004, 0);
      vecs[7]  = mk(0, 1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2, 1, 0, 1, 4'd1, 32'hA1, 15'h0002, 0);
      vecs[8]  = mk(0, 1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2, 0, 1, 1, 4'd2, 32'hB2, 15'h0004, 0);
      vecs[9]  = mk(0, 1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2, 1, 0, 1, 4'd1, 32'hA1, 15'h0002, 0);
`else
      // A wins four times, then the starved B is forced through.
      vecs[4]  = mk(0, 1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2, 1, 0, 1, 4'd1, 32'hA1, 15'h0002, 0);
      vecs[5]  = mk(0, 1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2, 1, 0, 1, 4'd1, 32'hA1, 15'h0002, 0);
      vecs[6]  = mk(0, 1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2, 1, 0, 1, 4'd1, 32'hA1, 15'h0002, 0);
      vecs[7]  = mk(0, 1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2, 1, 0, 1, 4'd1, 32'hA1, 15'h0002, 0);
      vecs[8]  = mk(0, 1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2, 0, 1, 1, 4'd2, 32'hB2, 15'h0004, 0);
      vecs[9]  = mk(0, 1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2, 1, 0, 1, 4'd1, 32'hA1, 15'h0002, 0);
`endif
      vecs[10] = mk(0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 0, 0, 4'd1, 32'hA1, 15'h0, 0);
      vecs[11] = mk(0, 0, 4'd0, 32'h0, 1, 4'hF, 32'h55, 0, 1, 0, 4'd1, 32'hA1, 15'h0, 1);
      vecs[12] = mk(0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 0, 0, 4'd1, 32'hA1, 15'h0, 0);
      vecs[13] = mk(0, 1, 4'd5, 32'h1, 0, 4'd0, 32'h0, 1, 0, 1, 4'd5, 32'h1, 15'h0020, 0);
      vecs[14] = mk(0, 0, 4'd0, 32'h0, 1, 4'd5, 32'h2, 0, 1, 1, 4'd5, 32'h2, 15'h0020, 0);
      vecs[15] = mk(0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 0, 0, 4'd5, 32'h2, 15'h0, 0);
      vecs[16] = mk(0, 0, 4'd0, 32'h0, 1, 4'd5, 32'h3, 0, 1, 1, 4'd5, 32'h3, 15'h0020, 0);
      vecs[17] = mk(1, 1, 4'd6, 32'h7, 1, 4'd7, 32'h8, 0, 0, 0, 4'd0, 32'h0, 15'h0, 0);
      vecs[18] = mk(0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 0, 0, 4'd0, 32'h0, 15'h0, 0);

      applyStimulus(vecs[0]);

      for (int i = 0; i < NUM_VEC; i++) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         #1;
         check($sformatf("v%0d a_ready", i), 64'(a_ready), 64'(vecs[i].exp_a_ready));
         check($sformatf("v%0d b_ready", i), 64'(b_ready), 64'(vecs[i].exp_b_ready));
         if (i == 15) begin
            check("same-dest final reg5", 64'(regfile[5]), 64'(32'h2));
         end
         @(posedge clk);
         #1;
         checkOutput(i, vecs[i]);
      end

      // Hand sequence: both valid straight out of reset; A must be first in either mode.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; a_valid = 1'b1; a_dest = 4'd9; a_data = 32'h99;
      b_valid = 1'b1; b_dest = 4'd10; b_data = 32'hAA;
      #1;
      check("post-reset a_ready", 64'(a_ready), 64'(1'b1));
      check("post-reset b_ready", 64'(b_ready), 64'(1'b0));
      @(posedge clk);
      #1;
      check("post-reset dest", 64'(rf_reg_dest), 64'(4'd9));
      check("post-reset mask", 64'(pending_mask), 64'(15'h0200));
      @(negedge clk);
      a_valid = 1'b0; b_valid = 1'b0;
      @(posedge clk);
      #1;
      check("post-reset idle write", 64'(rf_reg_write), 64'(1'b0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
